// File: rtl/jtframe_mixer_agc.sv
// Automatic gain control for one mixer channel: soft start, fast attack on peak, hold, slow release.
// Optional stretched clip indicator built when JTFRAME_AGC_LED_EN is defined; otherwise peak_led is 0.
module jtframe_mixer_agc #(
    parameter logic [7:0] GMIN     = 8'h04,
    parameter logic [7:0] ATT_STEP = 8'h02,
    parameter int         HOLD_LEN = 1024,
    parameter int         REL_DIV  = 64,
    parameter int         LED_LEN  = 4096
)(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic [7:0] gain_set,
    input  logic       peak,
    output logic [7:0] gain_out,
    output logic       limiting,
    output logic       peak_led
);

    localparam int HW = (HOLD_LEN > 1) ? $clog2(HOLD_LEN) : 1;
    localparam int RW = (REL_DIV  > 1) ? $clog2(REL_DIV)  : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_LEN - 1);
    localparam logic [RW-1:0] REL_LAST  = RW'(REL_DIV - 1);

    typedef enum logic [1:0] {RAMP, STEADY, ATTACK, HOLD} state_t;

    state_t        st, st_nx;
    logic [HW-1:0] hold_cnt, hold_nx;
    logic [RW-1:0] rel_cnt, rel_nx;
    logic [7:0]    gain_nx, tgt, flr, att_gain;
    logic [8:0]    dec;

    assign tgt = gain_set;
    assign flr = (GMIN < gain_set) ? GMIN : gain_set;
    // 9-bit subtract so an underflow lands on the floor instead of wrapping to a loud gain
    assign dec      = {1'b0, gain_out} - {1'b0, ATT_STEP};
    assign att_gain = (dec[8] || dec[7:0] < flr) ? flr : dec[7:0];

    always_comb begin
        st_nx   = st;
        gain_nx = gain_out;
        hold_nx = hold_cnt;
        rel_nx  = rel_cnt;
        if (gain_out > tgt) begin
            gain_nx = tgt;
            if (st == RAMP || st == STEADY) st_nx = STEADY;
        end else if (peak) begin
            st_nx   = ATTACK;
            gain_nx = att_gain;
            hold_nx = '0;
        end else begin
            case (st)
                RAMP: begin
                    if (gain_out == tgt) begin
                        st_nx = STEADY;
                    end else if (rel_cnt == REL_LAST) begin
                        rel_nx  = '0;
                        gain_nx = gain_out + 8'd1;
                        if (gain_out + 8'd1 == tgt) st_nx = STEADY;
                    end else begin
                        rel_nx = rel_cnt + 1'b1;
                    end
                end
                STEADY: begin
                    if (gain_out < tgt) begin
                        st_nx  = RAMP;
                        rel_nx = '0;
                    end
                end
                ATTACK: begin
                    st_nx   = HOLD;
                    hold_nx = '0;
                end
                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        st_nx  = RAMP;
                        rel_nx = '0;
                    end else begin
                        hold_nx = hold_cnt + 1'b1;
                    end
                end
                default: st_nx = RAMP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= RAMP;
            gain_out <= 8'd0;
            hold_cnt <= '0;
            rel_cnt  <= '0;
            limiting <= 1'b0;
        end else if (cen) begin
            st       <= st_nx;
            gain_out <= gain_nx;
            hold_cnt <= hold_nx;
            rel_cnt  <= rel_nx;
            limiting <= (st_nx == ATTACK) || (st_nx == HOLD);
        end
    end

`ifdef JTFRAME_AGC_LED_EN
    localparam int LW = (LED_LEN > 1) ? $clog2(LED_LEN) : 1;
    logic [LW-1:0] led_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_cnt  <= '0;
            peak_led <= 1'b0;
        end else if (cen) begin
            if (peak) begin
                led_cnt  <= LW'(LED_LEN - 1);
                peak_led <= 1'b1;
            end else if (led_cnt != '0) begin
                led_cnt <= led_cnt - 1'b1;
            end else begin
                peak_led <= 1'b0;
            end
        end
    end
`else
    assign peak_led = 1'b0;
`endif

endmodule

// File: tb/tb_jtframe_mixer_agc.sv
// Directed bench for jtframe_mixer_agc: soft start, attack, hold/release, setpoint, async reset, LED stretch.
module tb_jtframe_mixer_agc;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cen = 1'b0;
    logic [7:0] gain_set = 8'h10;
    logic       peak = 1'b0;
    logic [7:0] gain_out;
    logic       limiting, peak_led;

    int checks = 0;
    int errors = 0;

`ifdef JTFRAME_AGC_LED_EN
    localparam logic LED_ON = 1'b1;
`else
    localparam logic LED_ON = 1'b0;
`endif

    jtframe_mixer_agc dut (
        .clk(clk), .rst_n(rst_n), .cen(cen), .gain_set(gain_set),
        .peak(peak), .gain_out(gain_out), .limiting(limiting), .peak_led(peak_led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // n cen pulses, one clk wide, spaced gap clk apart; returns on a negedge
    task automatic tick(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            cen = 1'b1;
            @(negedge clk);
            cen = 1'b0;
            repeat (gap - 1) @(negedge clk);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_gain", gain_out, 8'h00);
        chk("rst_lim", limiting, 1'b0);
        chk("rst_led", peak_led, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // soft start: +1 every 64 cen up to 0x10
        tick(63, 4);
        chk("ramp_pre", gain_out, 8'h00);
        for (int s = 1; s <= 16; s++) begin
            tick(1, 4);
            chk($sformatf("ramp_step%0d", s), gain_out, s);
            chk($sformatf("ramp_lim%0d", s), limiting, 1'b0);
            if (s < 16) begin
                tick(63, 4);
                chk($sformatf("ramp_hold%0d", s), gain_out, s);
            end
        end
        tick(10, 2);
        chk("steady", gain_out, 8'h10);

        // attack
        peak = 1'b1;
        tick(1, 2); chk("att1", gain_out, 8'h0E); chk("att1_lim", limiting, 1'b1);
        tick(1, 2); chk("att2", gain_out, 8'h0C);
        tick(1, 2); chk("att3", gain_out, 8'h0A);
        tick(20, 2); chk("att_floor", gain_out, 8'h04);

        // hold, then a peak pulse at hold_cnt=500 restarts the hold
        peak = 1'b0;
        tick(501, 2);
        chk("hold500_gain", gain_out, 8'h04);
        chk("hold500_lim", limiting, 1'b1);
        peak = 1'b1;
        tick(1, 2);
        chk("repeak_gain", gain_out, 8'h04);
        chk("repeak_lim", limiting, 1'b1);
        peak = 1'b0;
        tick(1024, 2);
        chk("hold_end_lim", limiting, 1'b1);
        chk("hold_end_gain", gain_out, 8'h04);
        tick(1, 2);
        chk("rel_lim", limiting, 1'b0);
        tick(63, 2);
        chk("rel_pre", gain_out, 8'h04);
        tick(1, 2);
        chk("rel_step", gain_out, 8'h05);
        tick(64 * 11 - 1, 2);
        chk("rel_almost", gain_out, 8'h0F);
        tick(1, 2);
        chk("rel_done", gain_out, 8'h10);
        tick(5, 2);
        chk("rel_steady", gain_out, 8'h10);

        // setpoint changes
        gain_set = 8'h08;
        tick(1, 2); chk("set8", gain_out, 8'h08);
        gain_set = 8'h00;
        tick(1, 2); chk("set0", gain_out, 8'h00);
        peak = 1'b1;
        tick(3, 2); chk("set0_peak", gain_out, 8'h00); chk("set0_lim", limiting, 1'b1);

        // raising the setpoint while limiting: next peak lands on the new floor
        gain_set = 8'h10;
        tick(1, 2); chk("floor_up", gain_out, 8'h04);
        tick(1, 2); chk("floor_stay", gain_out, 8'h04);

        // async reset mid-attack, between cen pulses
        #1 rst_n = 1'b0;
        #1;
        chk("arst_gain", gain_out, 8'h00);
        chk("arst_lim", limiting, 1'b0);
        peak = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tick(63, 2); chk("rs_pre", gain_out, 8'h00);
        tick(1, 2);  chk("rs_step1", gain_out, 8'h01);
        tick(64 * 15, 2); chk("rs_done", gain_out, 8'h10);
        chk("rs_lim", limiting, 1'b0);

        // stretched peak indicator
        peak = 1'b1;
        tick(1, 2);
        chk("led_set", peak_led, LED_ON);
        peak = 1'b0;
        tick(4095, 2); chk("led_last", peak_led, LED_ON);
        tick(1, 2);    chk("led_off", peak_led, 1'b0);
        tick(10, 2);
        peak = 1'b1;
        tick(1, 2);
        peak = 1'b0;
        tick(3999, 2);
        peak = 1'b1;
        tick(1, 2);
        peak = 1'b0;
        tick(96, 2);   chk("led_ext", peak_led, LED_ON);
        tick(3999, 2); chk("led_ext_last", peak_led, LED_ON);
        tick(1, 2);    chk("led_ext_off", peak_led, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
